// File: rtl/aes_key_sched_ctrl_if.sv
// Handshake bundle between the host/key register, the round-key consumer
// and the AES-128 key-schedule sequencer.
//   master : host + cipher core (drives start/key/abort/ready)
//   slave  : aes_key_sched_ctrl
interface aes_key_sched_ctrl_if #(
    parameter int WIDTH = 128
);
    logic             start_i;
    logic [WIDTH-1:0] key_i;
    logic             abort_i;
    logic             busy_o;
    logic             rk_valid_o;
    logic             rk_ready_i;
    logic [WIDTH-1:0] rk_o;
    logic [3:0]       rk_idx_o;
    logic             done_o;

    modport master (
        output start_i,
        output key_i,
        output abort_i,
        output rk_ready_i,
        input  busy_o,
        input  rk_valid_o,
        input  rk_o,
        input  rk_idx_o,
        input  done_o
    );

    modport slave (
        input  start_i,
        input  key_i,
        input  abort_i,
        input  rk_ready_i,
        output busy_o,
        output rk_valid_o,
        output rk_o,
        output rk_idx_o,
        output done_o
    );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule sequencer. Feeds an external registered round unit
// (1-cycle latency, no enable) in a loop and streams round keys 0..NR over
// a valid/ready handshake.
//
// Optional round-key cache: define AES_KEY_CACHE_EN to keep the last full
// schedule in an (NR+1)-entry array readable through rd_idx_i/rd_key_o.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | waiting for start_i; round unit sees cur_key with rcon 0
// S_EMIT | round key idx offered on rk_o; round unit fed cur_key/rc(idx+1)
// S_WAIT | round unit output for the next key is captured into cur_key
module aes_key_sched_ctrl #(
    parameter int WIDTH = 128,
    parameter int NR    = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    aes_key_sched_ctrl_if.slave  bus,
    output logic [WIDTH-1:0]     exp_key_o,
    output logic [WIDTH/4-1:0]   exp_rcon_o,
    input  logic [WIDTH-1:0]     exp_key_i,
    input  logic [3:0]           rd_idx_i,
    output logic [WIDTH-1:0]     rd_key_o,
    output logic                 cache_valid_o
);

    localparam logic [3:0] LP_LAST = 4'(NR);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_cur_key;
    logic [3:0]           r_idx;
    logic                 r_busy;
    logic                 r_rk_valid;
    logic                 r_done;
    logic [WIDTH/4-1:0]   r_rcon;

    logic                 w_hs;
    logic                 w_last_hs;

    // AES round constant rc(n), n = 1..10; anything else reads as 0.
    function automatic logic [7:0] f_rc(input logic [3:0] n);
        case (n)
            4'd1:    f_rc = 8'h01;
            4'd2:    f_rc = 8'h02;
            4'd3:    f_rc = 8'h04;
            4'd4:    f_rc = 8'h08;
            4'd5:    f_rc = 8'h10;
            4'd6:    f_rc = 8'h20;
            4'd7:    f_rc = 8'h40;
            4'd8:    f_rc = 8'h80;
            4'd9:    f_rc = 8'h1b;
            4'd10:   f_rc = 8'h36;
            default: f_rc = 8'h00;
        endcase
    endfunction

    // rcon word presented while emitting key idx; the last key needs no
    // further expansion so its constant is driven as 0.
    function automatic logic [WIDTH/4-1:0] f_rcon_word(input logic [3:0] idx);
        if (idx >= LP_LAST) begin
            f_rcon_word = '0;
        end else begin
            f_rcon_word = {f_rc(idx + 4'd1), 24'h0};
        end
    endfunction

    assign w_hs      = (r_state == S_EMIT) && bus.rk_ready_i;
    assign w_last_hs = w_hs && (r_idx == LP_LAST);

    // Sequencer FSM; all handshake/status outputs are registered here.
    // abort_i overrides every other input, including start and handshake.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= S_IDLE;
            r_cur_key  <= '0;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_rk_valid <= 1'b0;
            r_done     <= 1'b0;
            r_rcon     <= '0;
        end else begin
            r_done <= 1'b0;
            if (bus.abort_i) begin
                r_state    <= S_IDLE;
                r_busy     <= 1'b0;
                r_rk_valid <= 1'b0;
                r_rcon     <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start_i) begin
                            r_cur_key  <= bus.key_i;
                            r_idx      <= 4'd0;
                            r_state    <= S_EMIT;
                            r_busy     <= 1'b1;
                            r_rk_valid <= 1'b1;
                            r_rcon     <= f_rcon_word(4'd0);
                        end
                    end
                    S_EMIT: begin
                        if (w_last_hs) begin
                            r_state    <= S_IDLE;
                            r_busy     <= 1'b0;
                            r_rk_valid <= 1'b0;
                            r_done     <= 1'b1;
                            r_rcon     <= '0;
                        end else if (w_hs) begin
                            r_idx      <= r_idx + 4'd1;
                            r_state    <= S_WAIT;
                            r_rk_valid <= 1'b0;
                            r_rcon     <= '0;
                        end
                    end
                    S_WAIT: begin
                        // Round unit output reflects the inputs held during
                        // the previous EMIT cycle.
                        r_cur_key  <= exp_key_i;
                        r_state    <= S_EMIT;
                        r_rk_valid <= 1'b1;
                        r_rcon     <= f_rcon_word(r_idx);
                    end
                    default: begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_rk_valid <= 1'b0;
                        r_rcon     <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.busy_o     = r_busy;
    assign bus.rk_valid_o = r_rk_valid;
    assign bus.rk_o       = r_cur_key;
    assign bus.rk_idx_o   = r_idx;
    assign bus.done_o     = r_done;
    assign exp_key_o      = r_cur_key;
    assign exp_rcon_o     = r_rcon;

`ifdef AES_KEY_CACHE_EN
    logic [WIDTH-1:0] r_cache [0:NR];
    logic [WIDTH-1:0] r_rd_key;
    logic             r_cache_valid;

    // Store every accepted round key at its index; storage needs no reset
    // because cache_valid qualifies the contents.
    always_ff @(posedge clk_i) begin
        if (w_hs && !bus.abort_i) begin
            r_cache[r_idx] <= r_cur_key;
        end
    end

    // Schedule is complete with done_o; any new start or abort invalidates it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cache_valid <= 1'b0;
        end else if (bus.abort_i) begin
            r_cache_valid <= 1'b0;
        end else if (r_state == S_IDLE && bus.start_i) begin
            r_cache_valid <= 1'b0;
        end else if (w_last_hs) begin
            r_cache_valid <= 1'b1;
        end
    end

    // Registered read port; out-of-range indices return 0.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rd_key <= '0;
        end else if (rd_idx_i <= LP_LAST) begin
            r_rd_key <= r_cache[rd_idx_i];
        end else begin
            r_rd_key <= '0;
        end
    end

    assign rd_key_o      = r_rd_key;
    assign cache_valid_o = r_cache_valid;
`else
    logic w_unused_rd_idx;

    assign w_unused_rd_idx = ^rd_idx_i;
    assign rd_key_o        = '0;
    assign cache_valid_o   = 1'b0;
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl. A behavioural AES-128 round
// unit closes the loop; expected round keys come from a word-level key
// expansion model. Define AES_KEY_CACHE_EN to also exercise the cache.
module tb_aes_key_sched_ctrl;

    localparam int WIDTH = 128;
    localparam int NR    = 10;
    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    typedef logic [127:0] ks_t [0:10];

    logic         clk_i   = 1'b0;
    logic         rst_n_i = 1'b0;
    logic [127:0] exp_key_o;
    logic [31:0]  exp_rcon_o;
    logic [127:0] exp_key_i;
    logic [3:0]   rd_idx_i;
    logic [127:0] rd_key_o;
    logic         cache_valid_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]   sbox_tab [0:255];
    logic [127:0] ru_q = '0;

    aes_key_sched_ctrl_if #(.WIDTH(WIDTH)) bus ();

    aes_key_sched_ctrl #(.WIDTH(WIDTH), .NR(NR)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .bus           (bus),
        .exp_key_o     (exp_key_o),
        .exp_rcon_o    (exp_rcon_o),
        .exp_key_i     (exp_key_i),
        .rd_idx_i      (rd_idx_i),
        .rd_key_o      (rd_key_o),
        .cache_valid_o (cache_valid_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- AES arithmetic ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
        return 8'((x << k) | (x >> (8 - k)));
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] b);
        logic [7:0] inv = 8'h01;
        if (b == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, b);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    function automatic logic [7:0] rc_n(input int n);
        logic [7:0] rc = 8'h01;
        for (int i = 1; i < n; i++) rc = xtime(rc);
        return rc;
    endfunction

    // One key-expansion round, as the external round unit computes it.
    function automatic logic [127:0] round_step(input logic [127:0] k, input logic [31:0] rcon);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = sub_word({w3[23:0], w3[31:24]}) ^ rcon;
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Reference model: full 44-word FIPS-197 expansion.
    function automatic ks_t expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        ks_t         ks;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ks;
    endfunction

    // Bench round unit: registered, 1-cycle latency, no enable.
    always_ff @(posedge clk_i) ru_q <= round_step(exp_key_o, exp_rcon_o);
    assign exp_key_i = ru_q;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  128'(bus.busy_o), 128'(0));
        chk({tag, "_valid"}, 128'(bus.rk_valid_o), 128'(0));
        chk({tag, "_done"},  128'(bus.done_o), 128'(0));
        chk({tag, "_rk"},    bus.rk_o, 128'(0));
        chk({tag, "_idx"},   128'(bus.rk_idx_o), 128'(0));
        chk({tag, "_xkey"},  exp_key_o, 128'(0));
        chk({tag, "_rcon"},  128'(exp_rcon_o), 128'(0));
        chk({tag, "_rdkey"}, rd_key_o, 128'(0));
        chk({tag, "_cval"},  128'(cache_valid_o), 128'(0));
    endtask

    task automatic do_start(input logic [127:0] key);
        @(negedge clk_i);
        bus.start_i = 1'b1;
        bus.key_i   = key;
        @(posedge clk_i);
    endtask

    // Follows one expansion from the cycle after the accepting edge.
    // mode 0: ready tied high, exact timing checked
    // mode 1: 5-cycle stall at idx 3, random ready otherwise
    // mode 2: random ready, start pulsed at idx 5, restart in the done cycle
    // mode 3: abort at idx 6
    // mode 4: asynchronous reset at idx 4
    task automatic follow(input logic [127:0] key, input int mode,
                          output ks_t seen, output logic [127:0] next_key);
        ks_t          ks;
        int           n_hs = 0;
        int           stall = 0;
        bit           held = 0;
        bit           done_seen = 0;
        logic [127:0] held_rk = '0;
        logic [3:0]   held_idx = '0;
        logic [127:0] want_rcon;
        ks = expand(key);
        next_key = '0;
        for (int r = 0; r < 11; r++) seen[r] = '0;
        for (int cyc = 1; cyc <= 300 && !done_seen; cyc++) begin
            @(negedge clk_i);
            bus.start_i = 1'b0;
            if (cyc == 1) begin
                chk("first_valid", 128'(bus.rk_valid_o), 128'(1));
                chk("first_idx", 128'(bus.rk_idx_o), 128'(0));
`ifdef AES_KEY_CACHE_EN
                chk("start_clears_cache", 128'(cache_valid_o), 128'(0));
`endif
            end
            if (held) begin
                chk("stall_valid", 128'(bus.rk_valid_o), 128'(1));
                chk("stall_rk", bus.rk_o, held_rk);
                chk("stall_idx", 128'(bus.rk_idx_o), 128'(held_idx));
            end
            held = 0;
            if (bus.done_o) begin
                done_seen = 1;
                chk("done_count", 128'(n_hs), 128'(11));
                chk("done_busy", 128'(bus.busy_o), 128'(0));
                chk("done_valid", 128'(bus.rk_valid_o), 128'(0));
                if (mode == 0) chk("done_cycle", 128'(cyc), 128'(22));
                if (mode == 2) begin
                    next_key    = {$urandom, $urandom, $urandom, $urandom};
                    bus.start_i = 1'b1;
                    bus.key_i   = next_key;
                end
            end else begin
                chk("busy", 128'(bus.busy_o), 128'(1));
                if (bus.rk_valid_o && n_hs >= 11) begin
                    chk("extra_valid", 128'(bus.rk_valid_o), 128'(0));
                end else if (bus.rk_valid_o) begin
                    want_rcon = (n_hs < 10) ? 128'({rc_n(n_hs + 1), 24'h0}) : 128'(0);
                    chk("rk_idx", 128'(bus.rk_idx_o), 128'(n_hs));
                    chk("rk", bus.rk_o, ks[n_hs]);
                    chk("xkey", exp_key_o, ks[n_hs]);
                    chk("rcon", 128'(exp_rcon_o), want_rcon);
                    if (mode == 4 && n_hs == 4) begin
                        #2 rst_n_i = 1'b0;
                        #1 chk_all_zero("async_rst");
                        @(negedge clk_i);
                        rst_n_i = 1'b1;
                        return;
                    end
                    if (mode == 3 && n_hs == 6) begin
                        bus.abort_i    = 1'b1;
                        bus.rk_ready_i = 1'b1;
                        @(negedge clk_i);
                        bus.abort_i = 1'b0;
                        chk("abort_valid", 128'(bus.rk_valid_o), 128'(0));
                        chk("abort_busy", 128'(bus.busy_o), 128'(0));
                        chk("abort_cval", 128'(cache_valid_o), 128'(0));
                        for (int i = 0; i < 3; i++) begin
                            chk("abort_no_done", 128'(bus.done_o), 128'(0));
                            @(negedge clk_i);
                        end
                        return;
                    end
                    if (mode == 2 && n_hs == 5) begin
                        bus.start_i = 1'b1;
                        bus.key_i   = ~key;
                    end
                    if (mode == 1 && n_hs == 3 && stall < 5) begin
                        bus.rk_ready_i = 1'b0;
                        stall++;
                        chk("stall_rcon", 128'(exp_rcon_o), 128'h08000000);
                    end else if (mode == 0) begin
                        bus.rk_ready_i = 1'b1;
                    end else begin
                        bus.rk_ready_i = 1'($urandom_range(0, 1));
                    end
                    if (bus.rk_ready_i) begin
                        if (mode == 0) chk("hs_cycle", 128'(cyc), 128'(1 + 2*n_hs));
                        seen[n_hs] = bus.rk_o;
                        n_hs++;
                    end else begin
                        held     = 1;
                        held_rk  = bus.rk_o;
                        held_idx = bus.rk_idx_o;
                    end
                end else begin
                    bus.rk_ready_i = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                end
            end
        end
        if (!done_seen) chk("timeout_done", 128'(done_seen), 128'(1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        ks_t          seen;
        ks_t          ref_ks;
        logic [127:0] nk;
        logic [127:0] k;
        int           r;

        bus.start_i    = 1'b0;
        bus.key_i      = '0;
        bus.abort_i    = 1'b0;
        bus.rk_ready_i = 1'b0;
        rd_idx_i       = 4'd0;
        for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));

        #12 chk_all_zero("reset");
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // FIPS-197 vector, ready tied high
        do_start(FIPS_KEY);
        follow(FIPS_KEY, 0, seen, nk);
        chk("fips_idx0", seen[0], FIPS_KEY);
        chk("fips_idx1", seen[1], FIPS_RK1);
        chk("fips_idx10", seen[10], FIPS_RK10);
`ifdef AES_KEY_CACHE_EN
        chk("cache_valid_done", 128'(cache_valid_o), 128'(1));
        rd_idx_i = 4'd10;
        @(negedge clk_i);
        chk("cache_rd10", rd_key_o, FIPS_RK10);
        rd_idx_i = 4'd12;
        @(negedge clk_i);
        chk("cache_rd12", rd_key_o, 128'(0));
        r = $urandom_range(0, 10);
        ref_ks = expand(FIPS_KEY);
        rd_idx_i = 4'(r);
        @(negedge clk_i);
        chk("cache_rd_rand", rd_key_o, ref_ks[r]);
`else
        rd_idx_i = 4'd10;
        @(negedge clk_i);
        chk("nocache_rd", rd_key_o, 128'(0));
        chk("nocache_cval", 128'(cache_valid_o), 128'(0));
`endif

        // Stall at idx 3 plus random ready
        do_start(FIPS_KEY);
        follow(FIPS_KEY, 1, seen, nk);
        chk("stall_fips_idx10", seen[10], FIPS_RK10);

        // Ignored start mid-run, then restart in the done cycle
        do_start(FIPS_KEY);
        follow(FIPS_KEY, 2, seen, nk);
        chk("ignored_start_idx10", seen[10], FIPS_RK10);
        @(posedge clk_i);
        follow(nk, 0, seen, k);
        chk("chained_idx0", seen[0], nk);

        // Abort at idx 6, then immediate restart
        do_start(FIPS_KEY);
        follow(FIPS_KEY, 3, seen, nk);
        do_start(FIPS_KEY);
        follow(FIPS_KEY, 0, seen, nk);
        chk("after_abort_idx10", seen[10], FIPS_RK10);

        // Asynchronous reset at idx 4, then fresh start
        k = {$urandom, $urandom, $urandom, $urandom};
        do_start(k);
        follow(k, 4, seen, nk);
        chk_all_zero("after_rst_idle");
        do_start(FIPS_KEY);
        follow(FIPS_KEY, 0, seen, nk);
        chk("after_rst_idx1", seen[1], FIPS_RK1);

        // Random keys with random ready behaviour
        for (int t = 0; t < 6; t++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            ref_ks = expand(k);
            do_start(k);
            follow(k, int'($urandom_range(0, 1)), seen, nk);
            chk("rand_idx10", seen[10], ref_ks[10]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
